alu_op_fifo: RTL and testbench
==============================

Name: alu_op_fifo

Overview:
- Operation queue directly upstream of the 32-bit ALU. Buffers {command, operandA, operandB} triples from the issue logic and presents them in order on the ALU input operands.
- Decouples the issuing source from ALU consumption using a valid/ready handshake on both sides.
- Produces occupancy status and supports a synchronous flush.

Parameters:
- DEPTH, 4, number of entries. Must be a power of 2, >= 2.
- CW, 3, command width; matches the ALU command input.
- DW, 32, operand width; matches the ALU operandA/operandB inputs.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all queued entries
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  queue can accept an operation this cycle
- in_command  input  CW  ALU command to enqueue
- in_operandA  input  DW  operand A to enqueue
- in_operandB  input  DW  operand B to enqueue
- out_valid  output  1  head entry valid toward ALU
- out_ready  input  1  ALU stage consumes head this cycle
- out_command  output  CW  head command, to ALU command
- out_operandA  output  DW  head operand A, to ALU operandA
- out_operandB  output  DW  head operand B, to ALU operandB
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset is asynchronous and active-high on clk domain: reset clears wr_ptr, rd_ptr and count to 0 and zeroes all storage entries.
  - After reset: out_valid=0, out_command=0, out_operandA=0, out_operandB=0, count=0, in_ready=1.
- Push occurs when in_valid && in_ready at a clk rising edge. The entry is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready at a clk rising edge. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). It depends on registered state only; there is no combinational path from out_ready.
- out_valid = (count != 0). Output data are read combinationally from entry[rd_ptr].
- Latency: an entry pushed at edge N appears on the outputs after edge N, i.e. usable in cycle N+1.
- count updates as follows:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
- Full (count==DEPTH): in_ready=0; in_valid is ignored. A pop in that cycle frees a slot, and in_ready rises the next cycle.
- Empty (count==0): out_valid=0; out_ready is ignored. A push in that cycle makes out_valid=1 the next cycle.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering is strictly FIFO across the wrap.
- flush has priority over push and pop in the same cycle:
  - rd_ptr and wr_ptr reset to 0 and count to 0.
  - A coincident push is dropped.
  - Storage contents need not be cleared.
- Output data while out_valid=0 are don't-care, except immediately after reset, when they are 0.
- Payload passes unmodified. No interpretation of the command bits.
- Reset mid-stream: all queued entries are lost immediately, without waiting for a clock edge.

Optional Feature:
ALU_OP_FIFO_BYPASS_EN
- Defined: when count==0, in_valid=1, out_ready=1 and flush=0, the input passes combinationally to the outputs with out_valid=1 in the same cycle.
  - The operation counts as consumed: nothing is written, and pointers and count are unchanged.
  - If out_ready=0, a normal push occurs.
- Undefined: no bypass; minimum latency is one cycle as described above.

Test Plan:
- Reset with queue holding 3 entries, assert reset between edges -> count=0, out_valid=0, outputs 0, in_ready=1 immediately.
- Push cmd=3'b010, A=32'h0000_0005, B=32'h0000_0003 with out_ready=0 -> next cycle out_valid=1, outputs match, count=1.
- Push 4 ops (A=1,2,3,4), out_ready=0 -> count=4, in_ready=0. A 5th push (A=5) is not accepted. Then pop all 4 -> A=1,2,3,4 in order, count=0.
- With count=4, assert in_valid and out_ready together -> pop A=1 only, count=3. Next cycle push accepted, count stays 3.
- Push 10 ops (A=0..9) while popping continuously with out_ready=1 -> output sequence 0..9 with no loss across pointer wrap.
- Queue holding 2 entries, assert flush and in_valid together -> next cycle count=0, out_valid=0. The coincident entry never appears.
- With ALU_OP_FIFO_BYPASS_EN defined, empty queue, in_valid=1 and out_ready=1, A=32'hDEAD_BEEF -> out_operandA=32'hDEAD_BEEF and out_valid=1 in the same cycle, count remains 0.

Source files
------------

// File: rtl/alu_op_fifo.sv
// Operation queue feeding the 32-bit ALU: buffers {command, operandA, operandB} with valid/ready on both sides.
// Optional same-cycle bypass on an empty queue is enabled by defining ALU_OP_FIFO_BYPASS_EN.
module alu_op_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_command,
  input  logic [DW-1:0]            in_operandA,
  input  logic [DW-1:0]            in_operandB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_command,
  output logic [DW-1:0]            out_operandA,
  output logic [DW-1:0]            out_operandB,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [CW-1:0] cmd_mem [DEPTH];
  logic [DW-1:0] a_mem   [DEPTH];
  logic [DW-1:0] b_mem   [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] cnt;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_FULL);

`ifdef ALU_OP_FIFO_BYPASS_EN
  // An empty queue with a ready ALU hands the operation straight through; nothing is stored.
  assign bypass = empty && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready = !full;
  assign push     = in_valid && !full && !flush && !bypass;
  assign pop      = !empty && out_ready && !flush;

  assign out_valid    = !empty || bypass;
  assign out_command  = bypass ? in_command  : cmd_mem[rd_ptr];
  assign out_operandA = bypass ? in_operandA : a_mem[rd_ptr];
  assign out_operandB = bypass ? in_operandB : b_mem[rd_ptr];
  assign count        = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem[i] <= '0;
        a_mem[i]   <= '0;
        b_mem[i]   <= '0;
      end
    end else if (push) begin
      cmd_mem[wr_ptr] <= in_command;
      a_mem[wr_ptr]   <= in_operandA;
      b_mem[wr_ptr]   <= in_operandB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_fifo.sv
// Directed bench for alu_op_fifo: queue-based reference model checked every cycle plus literal expectations.
module tb_alu_op_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_command;
  logic [31:0] in_operandA;
  logic [31:0] in_operandB;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_command;
  logic [31:0] out_operandA;
  logic [31:0] out_operandB;
  logic [2:0]  count;

  alu_op_fifo #(.DEPTH(DEPTH), .CW(3), .DW(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_operandA(in_operandA), .in_operandB(in_operandB),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_command(out_command), .out_operandA(out_operandA), .out_operandB(out_operandB),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t q[$];
  bit  fresh = 1'b1;
  bit  chk_en = 1'b0;
  bit  rec_en = 1'b0;
  logic [31:0] got[$];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_OP_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated from the handshake rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      fresh = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      bit byp, do_pop, do_push;
      byp     = BYP && (q.size() == 0) && in_valid && out_ready;
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH) && !byp;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{in_command, in_operandA, in_operandB});
        fresh = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      bit byp;
      byp = BYP && (q.size() == 0) && in_valid && out_ready && !flush;
      check("m_count", 64'(count), 64'(q.size()));
      check("m_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("m_out_valid", 64'(out_valid), 64'((q.size() != 0) || byp));
      if (byp) begin
        check("m_byp_cmd", 64'(out_command), 64'(in_command));
        check("m_byp_A", 64'(out_operandA), 64'(in_operandA));
        check("m_byp_B", 64'(out_operandB), 64'(in_operandB));
      end else if (q.size() != 0) begin
        check("m_cmd", 64'(out_command), 64'(q[0].c));
        check("m_A", 64'(out_operandA), 64'(q[0].a));
        check("m_B", 64'(out_operandB), 64'(q[0].b));
      end else if (fresh) begin
        check("m_zero_data", {29'd0, out_command, out_operandA}, 64'd0);
      end
    end
    if (rec_en && out_valid && out_ready && !flush)
      got.push_back(out_operandA);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_command = c; in_operandA = a; in_operandB = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_command = '0; in_operandA = '0; in_operandB = '0;
    repeat (2) step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data", {29'd0, out_command, out_operandA}, 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // single push, one-cycle latency
    put(3'b010, 32'h5, 32'h3);
    check("p1_valid", 64'(out_valid), 64'd1);
    check("p1_cmd", 64'(out_command), 64'd2);
    check("p1_A", 64'(out_operandA), 64'd5);
    check("p1_B", 64'(out_operandB), 64'd3);
    check("p1_count", 64'(count), 64'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("p1_flushed", 64'(count), 64'd0);

    // fill, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) put(3'(i), 32'(i), 32'(i * 16));
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    put(3'd5, 32'd5, 32'd80);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_head", 64'(out_operandA), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_A", 64'(out_operandA), 64'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);

    // full with simultaneous in_valid and out_ready
    for (int i = 1; i <= 4; i++) put(3'(i), 32'(i), 32'(i));
    in_valid = 1'b1; in_operandA = 32'd9; out_ready = 1'b1;
    check("fp_head", 64'(out_operandA), 64'd1);
    step();
    check("fp_count", 64'(count), 64'd3);
    check("fp_in_ready", 64'(in_ready), 64'd1);
    check("fp_head2", 64'(out_operandA), 64'd2);
    in_operandA = 32'd10;
    step();
    in_valid = 1'b0;
    check("fp2_count", 64'(count), 64'd3);
    check("fp2_head", 64'(out_operandA), 64'd3);
    for (int k = 0; k < 10 && out_valid; k++) step();
    out_ready = 1'b0;
    check("fp_drained", 64'(count), 64'd0);

    // streaming across pointer wrap
    got.delete();
    rec_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_command = 3'(i); in_operandA = 32'(i); in_operandB = 32'(100 + i);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && out_valid; k++) step();
    rec_en = 1'b0; out_ready = 1'b0;
    check("stream_len", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      check("stream_A", 64'(got[i]), 64'(i));

    // flush beats a coincident push
    put(3'd1, 32'd20, 32'd0);
    put(3'd1, 32'd21, 32'd0);
    check("fl_pre", 64'(count), 64'd2);
    flush = 1'b1; in_valid = 1'b1; in_operandA = 32'd77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    step();
    check("fl_valid2", 64'(out_valid), 64'd0);
    put(3'd6, 32'd30, 32'd31);
    check("fl_next_head", 64'(out_operandA), 64'd30);
    flush = 1'b1; step(); flush = 1'b0;

    // empty queue with in_valid and out_ready together
    in_valid = 1'b1; in_command = 3'd7; in_operandA = 32'hDEAD_BEEF; in_operandB = 32'h1234; out_ready = 1'b1;
    #1;
`ifdef ALU_OP_FIFO_BYPASS_EN
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_A", 64'(out_operandA), 64'hDEAD_BEEF);
    check("byp_count", 64'(count), 64'd0);
    step();
    in_valid = 1'b0;
    check("byp_count_after", 64'(count), 64'd0);
`else
    check("nobyp_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    check("nobyp_valid_after", 64'(out_valid), 64'd1);
    check("nobyp_A", 64'(out_operandA), 64'hDEAD_BEEF);
    step();
    check("nobyp_count", 64'(count), 64'd0);
`endif
    out_ready = 1'b0;

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) put(3'(i + 1), 32'(50 + i), 32'(60 + i));
    check("ar_pre", 64'(count), 64'd3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    check("ar_data", {29'd0, out_command, out_operandA}, 64'd0);
    check("ar_B", 64'(out_operandB), 64'd0);
    step();
    #2;
    reset = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
